// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: request/grant bundle between requesters and the mux arbiter
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic [3:0] busy_cnt;
   modport master (output req, input grant, sel, valid, busy_cnt);
   modport slave  (input req, output grant, sel, valid, busy_cnt);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8:1 mux select with bounded tenure
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   mux8_rr_arbiter_if.slave        bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state_q, state_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] mask, rot;
   logic [2:0] off, win;
   logic       hold, at_max, rotate;
   always_comb begin
      // while granted, ptr_q is the owner, so one search from ptr_q+1 serves every case
      mask = state_q == GRANT ? bus.req & ~(8'd1 << sel_q) : bus.req;
      for (int i = 0; i < 8; i++) rot[i] = mask[3'(ptr_q + 3'(i) + 3'd1)];
      off = 3'd0;
      for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
      win    = ptr_q + off + 3'd1;
      hold   = state_q == GRANT && bus.req[sel_q];
      at_max = cnt_q == 4'(MAX_HOLD);
      rotate = |mask && (!hold || at_max);
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (rotate) begin
         state_d = GRANT;
         grant_d = 8'd1 << win;
         sel_d   = win;
         ptr_d   = win;
         cnt_d   = 4'd1;
      end else if (hold) begin
         cnt_d = at_max ? cnt_q : cnt_q + 4'd1;
      end else begin
         state_d = IDLE;
         grant_d = 8'd0;
         cnt_d   = 4'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 8'd0;
         sel_q   <= 3'd0;
         ptr_q   <= 3'd7;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.grant    = grant_q;
   assign bus.sel      = sel_q;
   assign bus.valid    = state_q == GRANT;
   assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed checks of rotation, hold limit, handover and reset
module tb_mux8_rr_arbiter;
   logic clk, rst;
   int   n_cmp, n_err;
   mux8_rr_arbiter_if bus();
   mux8_rr_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                          input logic v, input logic [3:0] b);
      chk({tag, "_grant"}, bus.grant, g);
      chk({tag, "_sel"}, {5'd0, bus.sel}, {5'd0, s});
      chk({tag, "_valid"}, {7'd0, bus.valid}, {7'd0, v});
      chk({tag, "_busy"}, {4'd0, bus.busy_cnt}, {4'd0, b});
   endtask
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.req = 8'h00;
      step();
      chk_all("reset", 8'h00, 3'd0, 1'b0, 4'd0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk_all("idle", 8'h00, 3'd0, 1'b0, 4'd0);
      end
      bus.req = 8'hFF;
      for (int c = 0; c < 36; c++) begin
         step();
         chk_all("all_req", 8'd1 << ((c / 4) % 8), 3'((c / 4) % 8), 1'b1, 4'((c % 4) + 1));
      end
      rst = 1'b1;
      step();
      chk_all("reset2", 8'h00, 3'd0, 1'b0, 4'd0);
      rst = 1'b0;
      bus.req = 8'h04;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk_all("solo2", 8'h04, 3'd2, 1'b1, k > 4 ? 4'd4 : 4'(k));
      end
      bus.req = 8'h24;
      step();
      chk_all("rot_to5", 8'h20, 3'd5, 1'b1, 4'd1);
      bus.req = 8'h08;
      step();
      chk_all("hand_to3", 8'h08, 3'd3, 1'b1, 4'd1);
      bus.req = 8'h81;
      step();
      chk_all("hand_to7", 8'h80, 3'd7, 1'b1, 4'd1);
      bus.req = 8'h00;
      step();
      chk_all("drop_idle", 8'h00, 3'd7, 1'b0, 4'd0);
      step();
      chk_all("stay_idle", 8'h00, 3'd7, 1'b0, 4'd0);
      bus.req = 8'h40;
      step();
      chk_all("grant6", 8'h40, 3'd6, 1'b1, 4'd1);
      bus.req = 8'h01;
      step();
      chk_all("wrap_to0", 8'h01, 3'd0, 1'b1, 4'd1);
      for (int k = 2; k <= 4; k++) begin
         step();
         chk_all("hold0", 8'h01, 3'd0, 1'b1, 4'(k));
      end
      bus.req = 8'h41;
      step();
      chk_all("expire_to6", 8'h40, 3'd6, 1'b1, 4'd1);
      bus.req = 8'h20;
      step();
      chk_all("hand_to5", 8'h20, 3'd5, 1'b1, 4'd1);
      step();
      chk_all("hold5", 8'h20, 3'd5, 1'b1, 4'd2);
      rst = 1'b1;
      step();
      chk_all("mid_reset", 8'h00, 3'd0, 1'b0, 4'd0);
      rst = 1'b0;
      bus.req = 8'hFF;
      step();
      chk_all("post_reset", 8'h01, 3'd0, 1'b1, 4'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
